// File: rtl/serial_frame_aligner_if.sv
// serial_frame_aligner_if
//   Line-side and payload-side signals of the receive frame aligner.
//   master : serial source / payload consumer (drives bit_en, serial_in)
//   slave  : the aligner itself
//   bit_en, serial_in         : one qualified line bit per bit_en cycle
//   recovered_data/data_valid : aligned payload byte + one-cycle strobe
//   sof                       : first payload byte of a frame
//   locked, sync_err          : alignment status / missed sync strobe
//   sync_err_cnt              : saturating missed-sync count (ALIGNER_ERRCNT_EN only)
interface serial_frame_aligner_if;
    logic       bit_en;
    logic       serial_in;
    logic [7:0] recovered_data;
    logic       data_valid;
    logic       sof;
    logic       locked;
    logic       sync_err;
`ifdef ALIGNER_ERRCNT_EN
    logic [15:0] sync_err_cnt;

    modport master (output bit_en, serial_in,
                    input  recovered_data, data_valid, sof, locked, sync_err, sync_err_cnt);
    modport slave  (input  bit_en, serial_in,
                    output recovered_data, data_valid, sof, locked, sync_err, sync_err_cnt);
`else
    modport master (output bit_en, serial_in,
                    input  recovered_data, data_valid, sof, locked, sync_err);
    modport slave  (input  bit_en, serial_in,
                    output recovered_data, data_valid, sof, locked, sync_err);
`endif
endinterface

// File: rtl/serial_frame_aligner.sv
// serial_frame_aligner
//   Receive-side deserializer and frame aligner. Hunts for SYNC_WORD on the
//   MSB-first serial line, confirms it CONFIRM_SYNCS more times at the frame
//   period, then delivers byte-aligned payload. LOSS_SYNCS consecutive missed
//   syncs while locked force a re-hunt.
//   Ports:
//     main_clk : sole clock, rising edge
//     rst      : synchronous active-high reset
//     lnk      : serial_frame_aligner_if.slave (line bits in, payload/status out)
//   Optional feature macro: ALIGNER_ERRCNT_EN adds the 16-bit saturating
//   sync_err_cnt, cleared only by rst.
module serial_frame_aligner #(
    parameter logic [7:0] SYNC_WORD     = 8'hBC,
    parameter int         PAYLOAD_BYTES = 4,
    parameter int         CONFIRM_SYNCS = 2,
    parameter int         LOSS_SYNCS    = 3
) (
    input  logic                   main_clk,
    input  logic                   rst,
    serial_frame_aligner_if.slave  lnk
);
    localparam int IDX_W = $clog2(PAYLOAD_BYTES + 1);

    typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;

    state_t           state, state_nxt;
    logic [7:0]       sr, sr_d, sr_nxt;
    logic [2:0]       bit_cnt, bit_cnt_d;
    logic [IDX_W-1:0] byte_idx, byte_idx_d;
    logic [2:0]       conf_cnt, conf_d;
    logic [2:0]       miss_cnt, miss_d;
    logic [7:0]       data_q, data_d;
    logic             dv_q, dv_d;
    logic             sof_q, sof_d;
    logic             err_q, err_d;
    logic             byte_done, slot, sync_ok;

    assign sr_nxt    = {sr[6:0], lnk.serial_in};
    assign byte_done = lnk.bit_en && (bit_cnt == 3'd7);
    assign slot      = (byte_idx == IDX_W'(PAYLOAD_BYTES));
    assign sync_ok   = (sr_nxt == SYNC_WORD);

    always_comb begin
        state_nxt  = state;
        sr_d       = lnk.bit_en ? sr_nxt : sr;
        bit_cnt_d  = lnk.bit_en ? bit_cnt + 3'd1 : bit_cnt;
        byte_idx_d = byte_idx;
        conf_d     = conf_cnt;
        miss_d     = miss_cnt;
        data_d     = data_q;
        dv_d       = 1'b0;
        sof_d      = 1'b0;
        err_d      = 1'b0;

        // The sync slot is the last byte of a frame; the index wraps after it.
        if (byte_done)
            byte_idx_d = slot ? '0 : byte_idx + IDX_W'(1);

        unique case (state)
            HUNT: begin
                // Position is meaningless while hunting; a hit defines bit 0 of payload byte 0.
                bit_cnt_d  = '0;
                byte_idx_d = '0;
                if (lnk.bit_en && sync_ok) begin
                    state_nxt = CONFIRM;
                    conf_d    = '0;
                end
            end
            CONFIRM: begin
                if (byte_done && slot) begin
                    if (!sync_ok) begin
                        state_nxt = HUNT;
                        conf_d    = '0;
                    end else if (conf_cnt + 3'd1 == 3'(CONFIRM_SYNCS)) begin
                        state_nxt = LOCKED;
                        conf_d    = '0;
                        miss_d    = '0;
                    end else begin
                        conf_d = conf_cnt + 3'd1;
                    end
                end
            end
            LOCKED: begin
                if (byte_done) begin
                    if (!slot) begin
                        data_d = sr_nxt;
                        dv_d   = 1'b1;
                        sof_d  = (byte_idx == '0);
                    end else if (sync_ok) begin
                        miss_d = '0;
                    end else begin
                        err_d = 1'b1;
                        // Alignment is kept until the miss threshold is reached.
                        if (miss_cnt + 3'd1 == 3'(LOSS_SYNCS)) begin
                            state_nxt = HUNT;
                            miss_d    = '0;
                        end else begin
                            miss_d = miss_cnt + 3'd1;
                        end
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge main_clk) begin
        if (rst) begin
            state    <= HUNT;
            sr       <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            conf_cnt <= '0;
            miss_cnt <= '0;
            data_q   <= '0;
            dv_q     <= 1'b0;
            sof_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            sr       <= sr_d;
            bit_cnt  <= bit_cnt_d;
            byte_idx <= byte_idx_d;
            conf_cnt <= conf_d;
            miss_cnt <= miss_d;
            data_q   <= data_d;
            dv_q     <= dv_d;
            sof_q    <= sof_d;
            err_q    <= err_d;
        end
    end

    assign lnk.recovered_data = data_q;
    assign lnk.data_valid     = dv_q;
    assign lnk.sof            = sof_q;
    assign lnk.locked         = (state == LOCKED);
    assign lnk.sync_err       = err_q;

`ifdef ALIGNER_ERRCNT_EN
    // Survives re-hunt; only rst clears it.
    logic [15:0] err_cnt;

    always_ff @(posedge main_clk) begin
        if (rst)
            err_cnt <= '0;
        else if (err_d && err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'd1;
    end

    assign lnk.sync_err_cnt = err_cnt;
`endif
endmodule
